// File: rtl/uart_fifo.sv
// UART with a configurable frame format, show-ahead TX/RX FIFOs and per-byte RX error flags.
// All logic runs on clk; bit timing comes from an oversampling tick enable.

module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr_q];
    assign level   = level_q;

    always_comb begin
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        level_d = level_q;
        if (do_push && !do_pop)
            level_d = level_q + 1'b1;
        else if (do_pop && !do_push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr_q] <= wdata;
    end
endmodule

// state  | meaning
// IDLE   | line idle / waiting for a word (TX) or falling edge (RX)
// START  | start bit;  DATA: data bits LSB first;  PARITY: parity bit;  STOP: stop bit(s)
module uart_fifo #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int OVERSAMPLING    = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic [DATA_BITS-1:0]          tx_data_in,
    input  logic                          tx_valid_in,
    output logic                          tx_ready_out,
    output logic                          tx_busy_out,
    output logic                          tx_serial_out,
    input  logic                          rx_serial_in,
    output logic [DATA_BITS-1:0]          rx_data_out,
    output logic                          rx_parity_err_out,
    output logic                          rx_frame_err_out,
    output logic                          rx_valid_out,
    input  logic                          rx_ready_in,
    output logic                          rx_overrun_out,
    input  logic                          err_clr_in,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level_out,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_out
);
    localparam int OS_DIV  = BAUD_RATE * OVERSAMPLING;
    localparam int DIV_RAW = (CLOCK_FREQUENCY + OS_DIV / 2) / OS_DIV;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(2 * OVERSAMPLING);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int DB      = DATA_BITS;

    localparam logic [OW-1:0] BIT_END  = OW'(OVERSAMPLING - 1);
    localparam logic [OW-1:0] HALF_END = OW'(OVERSAMPLING / 2 - 1);
    localparam logic [OW-1:0] STOP_END = OW'(STOP_BITS * OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic          overrun_q, overrun_d;
    logic          tick;

    logic          tx_pop, tx_full, tx_empty;
    logic [DB-1:0] tx_word;
    logic          rx_full, rx_empty;
    logic [DB+1:0] rx_head;

    state_e        tx_state_q;
    logic [OW-1:0] tx_os_q;
    logic [BW-1:0] tx_bit_q;
    logic [DB-1:0] tx_shift_q;
    logic          tx_par_q, tx_q, tx_avail_q;

    state_e        rx_state_q;
    logic [OW-1:0] rx_os_q;
    logic [BW-1:0] rx_bit_q;
    logic [DB-1:0] rx_shift_q;
    logic          rx_perr_q, rx_push_q;
    logic [DB+1:0] rx_word_q;

    assign tick = (tick_cnt_q == CW'(DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        sync1_d    = rx_serial_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        overrun_d  = overrun_q;
        if (err_clr_in)
            overrun_d = 1'b0;
        if (rx_push_q && rx_full && !rx_ready_in)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            tick_cnt_q <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_fifo_buf #(.W(DB), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst_in), .push(tx_valid_in && !tx_full), .wdata(tx_data_in),
        .pop(tx_pop), .rdata(tx_word), .full(tx_full), .empty(tx_empty), .level(tx_level_out)
    );

    uart_fifo_buf #(.W(DB + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst_in), .push(rx_push_q), .wdata(rx_word_q),
        .pop(rx_ready_in), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level_out)
    );

    // The start decision uses a registered copy of "FIFO non-empty" to keep the FIFO
    // level off the FSM's critical path; it is exact whenever the decision is taken.
    assign tx_pop = tick && tx_avail_q &&
                    ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_os_q == STOP_END));

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            tx_state_q <= S_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_avail_q <= 1'b0;
        end else begin
            tx_avail_q <= !tx_empty;
            if (tx_pop) begin
                tx_state_q <= S_START;
                tx_q       <= 1'b0;
                tx_os_q    <= '0;
                tx_shift_q <= tx_word;
                tx_par_q   <= (PARITY == 1) ? ~^tx_word : ^tx_word;
            end else if (tick) begin
                tx_os_q <= tx_os_q + 1'b1;
                case (tx_state_q)
                    S_START: if (tx_os_q == BIT_END) begin
                        tx_state_q <= S_DATA;
                        tx_q       <= tx_shift_q[0];
                        tx_os_q    <= '0;
                        tx_bit_q   <= '0;
                    end
                    S_DATA: if (tx_os_q == BIT_END) begin
                        tx_os_q <= '0;
                        if (tx_bit_q == LAST_BIT) begin
                            tx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                            tx_q       <= (PARITY != 0) ? tx_par_q : 1'b1;
                        end else begin
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 1'b1;
                        end
                    end
                    S_PARITY: if (tx_os_q == BIT_END) begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                        tx_os_q    <= '0;
                    end
                    S_STOP: if (tx_os_q == STOP_END) begin
                        tx_state_q <= S_IDLE;
                        tx_os_q    <= '0;
                    end
                    default: begin
                        tx_state_q <= S_IDLE;
                        tx_os_q    <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rx_state_q <= S_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_word_q  <= '0;
        end else begin
            rx_push_q <= 1'b0;
            if (tick)
                rx_os_q <= rx_os_q + 1'b1;
            case (rx_state_q)
                S_IDLE: begin
                    rx_os_q <= '0;
                    if (prev_q && !sync2_q) begin
                        rx_state_q <= S_START;
                        rx_perr_q  <= 1'b0;
                    end
                end
                S_START: if (tick && rx_os_q == HALF_END) begin
                    rx_os_q    <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= sync2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (tick && rx_os_q == BIT_END) begin
                    rx_os_q    <= '0;
                    rx_shift_q <= {sync2_q, rx_shift_q[DB-1:1]};
                    rx_bit_q   <= rx_bit_q + 1'b1;
                    if (rx_bit_q == LAST_BIT)
                        rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (tick && rx_os_q == BIT_END) begin
                    rx_os_q    <= '0;
                    rx_perr_q  <= sync2_q != ((PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q);
                    rx_state_q <= S_STOP;
                end
                S_STOP: if (tick && rx_os_q == BIT_END) begin
                    rx_push_q  <= 1'b1;
                    rx_word_q  <= {rx_perr_q, !sync2_q, rx_shift_q};
                    rx_state_q <= S_IDLE;
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready_out      = !tx_full;
    assign tx_busy_out       = (tx_state_q != S_IDLE) || !tx_empty;
    assign tx_serial_out     = tx_q;
    assign rx_data_out       = rx_head[DB-1:0];
    assign rx_frame_err_out  = rx_head[DB];
    assign rx_parity_err_out = rx_head[DB+1];
    assign rx_valid_out      = !rx_empty;
    assign rx_overrun_out    = overrun_q;
endmodule
